// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and access-size codes for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selector for the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority over fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  owner_e last_owner,
    output logic   grant_i,
    output logic   grant_d
);

`ifdef MEM_ARB_RR_EN
    // On contention, the port that was not served last wins.
    assign grant_d = data_req & (~inst_req | (last_owner != OWN_D));
`else
    logic unused_last;
    assign unused_last = ^last_owner;
    assign grant_d     = data_req;
`endif
    assign grant_i = inst_req & ~grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus between fetch and data ports, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    output logic              inst_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              data_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e state_q;
    owner_e owner_q;
    owner_e last_owner;
    logic   grant_i;
    logic   grant_d;
    logic   fin;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner_q;
    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    mem_arb_pick u_pick (
        .inst_req  (inst_req),
        .data_req  (data_req),
        .last_owner(last_owner),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    assign inst_stall = inst_req & ~inst_done;
    assign data_stall = data_req & ~data_done;
    // Data phase completes either together with address acceptance or later in DATA.
    assign fin = bus_data_ok & (((state_q == ST_ADDR) & bus_addr_ok) | (state_q == ST_DATA));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_I;
`endif
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_size   <= 2'd0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (grant_d || grant_i) begin
                    owner_q   <= grant_d ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
                    last_owner_q <= grant_d ? OWN_D : OWN_I;
`endif
                    bus_req   <= 1'b1;
                    bus_wr    <= grant_d & data_wr;
                    bus_size  <= grant_d ? data_size : SZ_WORD;
                    bus_addr  <= grant_d ? data_addr : inst_addr;
                    bus_wdata <= grant_d ? data_wdata : '0;
                    state_q   <= ST_ADDR;
                end
                ST_ADDR: if (bus_addr_ok) begin
                    bus_req <= 1'b0;
                    state_q <= bus_data_ok ? ST_RESP : ST_DATA;
                end
                ST_DATA: if (bus_data_ok) state_q <= ST_RESP;
                ST_RESP: begin
                    inst_done <= 1'b0;
                    data_done <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (fin) begin
                inst_done <= (owner_q == OWN_I);
                data_done <= (owner_q == OWN_D);
                if (owner_q == OWN_I) inst_rdata <= bus_rdata;
                if (owner_q == OWN_D && !bus_wr) data_rdata <= bus_rdata;
            end
        end
    end

endmodule
